// File: rtl/fnorm_pkg.sv
// Shared float-format helpers: packed field offsets and the most negative exponent.
package fnorm_pkg;

  localparam int MAN_LO = 0;

  function automatic int exp_lo(input int man_w);
    return man_w;
  endfunction

  function automatic int sign_pos(input int man_w, input int exp_w);
    return man_w + exp_w;
  endfunction

  function automatic int emin(input int exp_w);
    return -(1 << (exp_w - 1));
  endfunction

endpackage

// File: rtl/fnorm_lzc.sv
// Leading-zero counter; an all-zero mantissa reports MAN.
module fnorm_lzc #(
  parameter int MAN = 23
) (
  input  logic [MAN-1:0]         man,
  output logic [$clog2(MAN):0]   lz
);

  localparam int LZW = $clog2(MAN) + 1;

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    lz = LZW'(MAN);
    for (int i = 0; i < MAN; i++) begin
      if (man[i]) lz = LZW'(MAN - 1 - i);
    end
  end

endmodule

// File: rtl/fnorm_pipe.sv
// Pipelined float normaliser with valid/ready handshake on both sides.
module fnorm_pipe
  import fnorm_pkg::*;
#(
  parameter int MAN = 23,
  parameter int EXP = 8,
  parameter int STG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN+EXP:0]     in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [MAN+EXP:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_zero,
  output logic                 out_unf,
  output logic                 busy
);

  localparam int LZW      = $clog2(MAN) + 1;
  localparam int CW       = ((EXP + 1 > LZW) ? EXP + 1 : LZW) + 1;
  localparam int EXP_LO   = exp_lo(MAN);
  localparam int SIGN_POS = sign_pos(MAN, EXP);
  localparam logic [EXP:0]   EMIN_X = (EXP+1)'(emin(EXP));
  localparam logic [EXP-1:0] EMIN_E = EXP'(emin(EXP));

  logic           in_sign;
  logic [EXP-1:0] in_exp;
  logic [MAN-1:0] in_man;
  logic [LZW-1:0] in_lz;

  assign in_sign = in[SIGN_POS];
  assign in_exp  = in[EXP_LO +: EXP];
  assign in_man  = in[MAN_LO +: MAN];

  fnorm_lzc #(.MAN(MAN)) u_lzc (
    .man (in_man),
    .lz  (in_lz)
  );

  logic           src_sign;
  logic [EXP-1:0] src_exp;
  logic [MAN-1:0] src_man;
  logic [LZW-1:0] src_lz;
  logic           s1_valid;
  logic           out_load;

  logic           n_sign;
  logic [EXP-1:0] n_exp;
  logic [MAN-1:0] n_man;
  logic           n_zero;
  logic           n_unf;
  logic [EXP:0]   headroom;
  logic [CW-1:0]  hd_w;
  logic [CW-1:0]  lz_w;
  logic [CW-1:0]  sh;

  // Shift is limited by how far the exponent can fall before reaching EMIN.
  always_comb begin
    headroom = {src_exp[EXP-1], src_exp} - EMIN_X;
    hd_w     = CW'(headroom);
    lz_w     = CW'(src_lz);
    sh       = (lz_w < hd_w) ? lz_w : hd_w;
    n_sign   = src_sign;
    n_man    = src_man << sh;
    n_exp    = EXP'(CW'(src_exp) - sh);
    n_zero   = 1'b0;
    n_unf    = lz_w > hd_w;
    if (src_man == '0) begin
      n_exp  = EMIN_E;
      n_man  = '0;
      n_zero = 1'b1;
      n_unf  = 1'b0;
    end
  end

  generate
    if (STG == 2) begin : g_two
      logic           s1_sign;
      logic [EXP-1:0] s1_exp;
      logic [MAN-1:0] s1_man;
      logic [LZW-1:0] s1_lz;
      logic           in_load;

      assign out_load = s1_valid && (!out_valid || out_ready);
      assign in_ready = rst && (!s1_valid || out_load);
      assign in_load  = in_valid && in_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_valid <= 1'b0;
          s1_sign  <= 1'b0;
          s1_exp   <= '0;
          s1_man   <= '0;
          s1_lz    <= '0;
        end else if (in_load) begin
          s1_valid <= 1'b1;
          s1_sign  <= in_sign;
          s1_exp   <= in_exp;
          s1_man   <= in_man;
          s1_lz    <= in_lz;
        end else if (out_load) begin
          s1_valid <= 1'b0;
        end
      end

      assign src_sign = s1_sign;
      assign src_exp  = s1_exp;
      assign src_man  = s1_man;
      assign src_lz   = s1_lz;
    end else begin : g_one
      assign s1_valid = 1'b0;
      assign in_ready = rst && (!out_valid || out_ready);
      assign out_load = in_valid && in_ready;
      assign src_sign = in_sign;
      assign src_exp  = in_exp;
      assign src_man  = in_man;
      assign src_lz   = in_lz;
    end
  endgenerate

  // Output registers only change on a load, so a stalled result holds still.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_zero  <= 1'b0;
      out_unf   <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out       <= {n_sign, n_exp, n_man};
      out_zero  <= n_zero;
      out_unf   <= n_unf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = s1_valid || out_valid;

endmodule

// File: tb/tb_fnorm_pipe.sv
// Directed self-checking bench: a 2-stage instance plus a 1-stage instance on one clock.
module tb_fnorm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in2, out2, in1, out1;
  logic        inValid2, inReady2, outValid2, outReady2, outZero2, outUnf2, busy2;
  logic        inValid1, inReady1, outValid1, outReady1, outZero1, outUnf1, busy1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fnorm_pipe #(.MAN(23), .EXP(8), .STG(2)) dut2 (
    .clk(clk), .rst(rst), .in(in2), .in_valid(inValid2), .in_ready(inReady2),
    .out(out2), .out_valid(outValid2), .out_ready(outReady2),
    .out_zero(outZero2), .out_unf(outUnf2), .busy(busy2)
  );

  fnorm_pipe #(.MAN(23), .EXP(8), .STG(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(inValid1), .in_ready(inReady1),
    .out(out1), .out_valid(outValid1), .out_ready(outReady1),
    .out_zero(outZero1), .out_unf(outUnf1), .busy(busy1)
  );

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] m);
    return {s, e, m};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // Sends one word to the chosen instance and checks latency and the result.
  task automatic applyStimulus(input string tag, input bit useOne, input logic [31:0] word,
                               input logic [31:0] want, input logic wantZero,
                               input logic wantUnf, input int wantLat);
    int n;
    @(negedge clk);
    if (useOne) begin inValid1 = 1'b1; in1 = word; end
    else        begin inValid2 = 1'b1; in2 = word; end
    #1;
    checkOutput({tag, "_inReady"}, useOne ? inReady1 : inReady2, 1);
    @(posedge clk);
    #1;
    inValid1 = 1'b0;
    inValid2 = 1'b0;
    n = 1;
    while (!(useOne ? outValid1 : outValid2) && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, n, wantLat);
    checkOutput({tag, "_word"}, useOne ? out1 : out2, want);
    checkOutput({tag, "_zero"}, useOne ? outZero1 : outZero2, wantZero);
    checkOutput({tag, "_unf"}, useOne ? outUnf1 : outUnf2, wantUnf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] stallIn [8];
    logic [31:0] stallOut [8];
    logic [7:0]  stallExp [8];
    logic [33:0] held;
    logic        prevStall;
    logic        sawBp;
    logic        acc;
    int          k, m;

    rst = 1'b0;
    in2 = '0; in1 = '0;
    inValid2 = 1'b0; inValid1 = 1'b0;
    outReady2 = 1'b1; outReady1 = 1'b1;

    #1;
    checkOutput("rst_outValid", outValid2, 0);
    checkOutput("rst_busy", busy2, 0);
    checkOutput("rst_inReady", inReady2, 0);
    checkOutput("rst_out", {outZero2, outUnf2, out2}, 0);
    checkOutput("rst_inReady1", inReady1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rel_inReady", inReady2, 1);
    checkOutput("rel_inReady1", inReady1, 1);

    applyStimulus("basic", 0, pack(0, 8'h05, 23'h000100), pack(0, 8'hF7, 23'h400000), 0, 0, 2);
    applyStimulus("zero", 0, pack(1, 8'h33, 23'h000000), pack(1, 8'h80, 23'h000000), 1, 0, 2);
    applyStimulus("clamp", 0, pack(0, 8'h82, 23'h000001), pack(0, 8'h80, 23'h000004), 0, 1, 2);
    applyStimulus("passthru", 0, pack(1, 8'h7F, 23'h7FFFFF), pack(1, 8'h7F, 23'h7FFFFF), 0, 0, 2);
    applyStimulus("atEmin", 0, pack(0, 8'h80, 23'h000010), pack(0, 8'h80, 23'h000010), 0, 1, 2);
    applyStimulus("expZero", 0, pack(0, 8'h00, 23'h000001), pack(0, 8'hEA, 23'h400000), 0, 0, 2);
    applyStimulus("one_same", 1, pack(0, 8'h10, 23'h400000), pack(0, 8'h10, 23'h400000), 0, 0, 1);
    applyStimulus("one_shift", 1, pack(1, 8'h00, 23'h000100), pack(1, 8'hF2, 23'h400000), 0, 0, 1);

    stallExp = '{8'h20, 8'h1F, 8'h1E, 8'h1D, 8'h1C, 8'h1B, 8'h1A, 8'h19};
    for (int i = 0; i < 8; i++) begin
      stallIn[i]  = pack(i[0], 8'h20, 23'h400000 >> i);
      stallOut[i] = pack(i[0], stallExp[i], 23'h400000);
    end

    // Back-to-back stream with the consumer stalled in cycles 3..7.
    k = 0; m = 0; prevStall = 1'b0; sawBp = 1'b0; held = '0;
    for (int c = 0; c < 60 && m < 8; c++) begin
      @(negedge clk);
      outReady2 = !(c >= 3 && c <= 7);
      inValid2  = (k < 8);
      in2       = (k < 8) ? stallIn[k] : '0;
      #1;
      acc = inValid2 && inReady2;
      if (inValid2 && !inReady2 && !sawBp) begin
        sawBp = 1'b1;
        checkOutput("bp_busy", busy2, 1);
        checkOutput("bp_outValid", outValid2, 1);
      end
      if (outValid2 && !outReady2) begin
        if (prevStall) checkOutput("stall_hold", {outZero2, outUnf2, out2}, held);
        held = {outZero2, outUnf2, out2};
        prevStall = 1'b1;
      end else begin
        prevStall = 1'b0;
      end
      if (outValid2 && outReady2) begin
        checkOutput("stream_word", out2, stallOut[m]);
        m++;
      end
      @(posedge clk);
      if (acc) k++;
    end
    inValid2 = 1'b0;
    outReady2 = 1'b1;
    checkOutput("stream_count", m, 8);
    checkOutput("stream_backpressure", sawBp, 1);

    // Reset pulse with two words in flight and the consumer stalled.
    @(negedge clk);
    outReady2 = 1'b0;
    inValid2 = 1'b1;
    in2 = pack(0, 8'h01, 23'h000001);
    @(posedge clk);
    @(negedge clk);
    in2 = pack(0, 8'h02, 23'h000002);
    @(posedge clk);
    @(negedge clk);
    inValid2 = 1'b0;
    #1;
    checkOutput("inflight_busy", busy2, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_outValid", outValid2, 0);
    checkOutput("midrst_busy", busy2, 0);
    checkOutput("midrst_inReady", inReady2, 0);
    checkOutput("midrst_out", {outZero2, outUnf2, out2}, 0);
    @(negedge clk);
    rst = 1'b1;
    outReady2 = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("no_stale", outValid2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnorm_pipe.md
FNORM_PIPE -- requirements
Module: fnorm_pipe

Interface
REQ-001 SHALL have parameter MAN, default 23: mantissa width in bits, allowed 4..52.
REQ-002 SHALL have parameter EXP, default 8: signed exponent width in bits, allowed 4..11.
REQ-003 SHALL have parameter STG, default 2: register stages, 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in, input, MAN+EXP+1 bits: packed word {sign, exponent (two's complement), mantissa}.
REQ-007 SHALL have port in_valid, input, 1 bit: in holds a word.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in this cycle.
REQ-009 SHALL have port out, output, MAN+EXP+1 bits: normalised word in the same packing.
REQ-010 SHALL have port out_valid, output, 1 bit: out holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts out this cycle.
REQ-012 SHALL have port out_zero, output, 1 bit: result mantissa is zero.
REQ-013 SHALL have port out_unf, output, 1 bit: exponent clamped, so the result is not fully normalised.
REQ-014 SHALL have port busy, output, 1 bit: at least one stage holds a valid word.

Function
REQ-015 SHALL define EMIN = -2^(EXP-1), the most negative exponent; lz = number of leading zeros of the mantissa (MSB = bit MAN-1).
REQ-016 SHALL compute shift amount sh = min(lz, exp - EMIN), computed without overflow in EXP+1 bits.
REQ-017 SHALL produce out mantissa = man << sh, out exponent = exp - sh, and out sign = in sign.
REQ-018 SHALL, for a zero mantissa, give out exponent EMIN, mantissa 0, out_zero=1, out_unf=0.
REQ-019 SHALL set out_unf=1 exactly when mantissa is nonzero and lz > exp - EMIN.
REQ-020 SHALL pass a word with mantissa MSB set through unchanged, with both flags 0.
REQ-021 SHALL, with STG=2, compute lz in stage 1 and do the shift, exponent update and flags in stage 2; with STG=1, do all of it in one stage.
REQ-022 SHALL give a latency of exactly STG cycles from the accept edge to out_valid, with no stall.
REQ-023 SHALL treat a transfer as happening on a cycle where valid and ready are both 1.
REQ-024 SHALL let a stage load when it is empty or when its contents leave in the same cycle.
REQ-025 SHALL collapse bubbles in the pipeline.
REQ-026 SHALL drive in_ready = (stage 1 empty) OR (stage 1 advancing); in_ready is combinational and does not depend on in_valid.
REQ-027 SHALL hold out, out_zero and out_unf stable while out_valid=1 and out_ready=0.
REQ-028 SHALL neither drop, duplicate nor reorder words, with throughput 1 word per cycle when out_ready=1.
REQ-029 SHALL, when accepting and emitting in the same cycle while full, do both with no loss.
REQ-030 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-031 SHALL, while rst=0, force all stage valid bits to 0 immediately.
REQ-032 SHALL force out_valid=0, busy=0 and in_ready=0 while rst=0.
REQ-033 SHALL clear data registers to 0 on reset, so out, out_zero and out_unf read 0.
REQ-034 SHALL discard in-flight words when reset is asserted mid-operation.
REQ-035 SHALL raise in_ready in the first cycle after rst rises.

Structure
REQ-036 SHALL place the EMIN derivation and the packed field offsets (sign, exponent, mantissa positions) in a shared float-format package, reused with the existing normaliser.
REQ-037 SHALL implement the leading-zero counter as one sub-module, fnorm_lzc, parameterised by MAN, with output width clog2(MAN)+1.
REQ-038 SHALL keep the handshake and stage registers in fnorm_pipe.

Verification (MAN=23, EXP=8, STG=2 unless stated)
REQ-039 SHALL cover: exp=0x05, man=0x000100 -> out exp=0xF7, man=0x400000, flags 0, out_valid 2 cycles after accept.
REQ-040 SHALL cover: man=0, exp=0x33, sign=1 -> sign 1, exp=0x80, man=0, out_zero=1, out_unf=0.
REQ-041 SHALL cover: exp=0x82, man=0x000001 -> exp=0x80, man=0x000004, out_unf=1.
REQ-042 SHALL cover: 8 back-to-back words with out_ready held 0 for cycles 3..7 -> in_ready falls once both stages are full, out stays stable during the stall, and all 8 words emerge in order, none lost.
REQ-043 SHALL cover: rst pulsed low with 2 words in flight -> out_valid and busy go 0 without a clock edge, and no stale word appears after release.
REQ-044 SHALL cover: STG=1 with exp=0x10, man=0x400000 -> the identical word out with 1-cycle latency and flags 0.
